am2951_fifo_port: RTL and testbench

//  Buffered successor to the 8-bit bidirectional latch port: two independent FIFOs
//  (R: A->B, S: B->A) of DEPTH words each, replacing the single holding registers.

---
 rtl/am2951_fifo_port_if.sv | 35 +++
 rtl/am2951_fifo_port.sv | 138 +++++++++++++
 tb/tb_am2951_fifo_port.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/am2951_fifo_port_if.sv
// Control and status bundle for both sides of the FIFO port; the tristate data buses stay plain ports.
// master: the bus-side agent driving strobes; slave: the FIFO port itself.
interface am2951_fifo_port_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          oea_;
    logic          cer_;
    logic          rds_;
    logic          clrr;
    logic          fr;
    logic          fullr;
    logic          ovr;
    logic [CW-1:0] cntr;

    logic          oeb_;
    logic          ces_;
    logic          rdr_;
    logic          clrs;
    logic          fs;
    logic          fulls;
    logic          ovs;
    logic [CW-1:0] cnts;

    modport master (
        output oea_, cer_, rds_, clrr, oeb_, ces_, rdr_, clrs,
        input  fr, fullr, ovr, cntr, fs, fulls, ovs, cnts
    );

    modport slave (
        input  oea_, cer_, rds_, clrr, oeb_, ces_, rdr_, clrs,
        output fr, fullr, ovr, cntr, fs, fulls, ovs, cnts
    );
endinterface

// File: rtl/am2951_fifo_port.sv
// Single-direction first-word-fall-through FIFO with sticky overflow and synchronous flush.
// Latency: pushed word is the head one clk after the push into an empty FIFO; pops expose the next word on the edge.
// Backpressure: none; a push into a full FIFO without a same-cycle pop is dropped and flagged.
module am2951_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clr_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   nempty_o,
    output logic                   full_o,
    output logic                   ovf_o,
    output logic [$clog2(DEPTH):0] cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ne_q, ne_d, full_q, full_d, ovf_q, ovf_d;
    logic             do_push, do_pop;

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign do_pop  = pop_i && ne_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            if (push_i && !do_push) ovf_d = 1'b1;
        end
        ne_d   = (cnt_d != '0);
        full_d = (cnt_d == CNT_FULL);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ne_q   <= 1'b0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ne_q   <= ne_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wptr_q] <= din_i;
    end

    assign head_o   = mem_q[rptr_q];
    assign nempty_o = ne_q;
    assign full_o   = full_q;
    assign ovf_o    = ovf_q;
    assign cnt_o    = cnt_q;
endmodule

// Bidirectional buffered bus port: R FIFO carries A->B, S FIFO carries B->A, heads driven onto the opposite bus.
// Latency: 1 clk from push to visible head on an empty FIFO; bus drivers are combinational on oe*_.
// Backpressure: none; full/overflow flags per direction, overflowing pushes are dropped.
module am2951_fifo_port #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter bit INVERT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_,
    inout  wire  [WIDTH-1:0]       a,
    inout  wire  [WIDTH-1:0]       b,
    am2951_fifo_port_if.slave      bus
);
    logic [WIDTH-1:0] r_head, s_head;
    logic [WIDTH-1:0] a_out, b_out;

    am2951_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_r (
        .clk      (clk),
        .rst_     (rst_),
        .push_i   (!bus.cer_),
        .pop_i    (!bus.rdr_),
        .clr_i    (bus.clrr),
        .din_i    (a),
        .head_o   (r_head),
        .nempty_o (bus.fr),
        .full_o   (bus.fullr),
        .ovf_o    (bus.ovr),
        .cnt_o    (bus.cntr)
    );

    am2951_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_s (
        .clk      (clk),
        .rst_     (rst_),
        .push_i   (!bus.ces_),
        .pop_i    (!bus.rds_),
        .clr_i    (bus.clrs),
        .din_i    (b),
        .head_o   (s_head),
        .nempty_o (bus.fs),
        .full_o   (bus.fulls),
        .ovf_o    (bus.ovs),
        .cnt_o    (bus.cnts)
    );

    // Loopback (push while driving the same bus) is intentionally unguarded.
    assign a_out = INVERT ? ~s_head : s_head;
    assign b_out = INVERT ? ~r_head : r_head;
    assign a = bus.oea_ ? {WIDTH{1'bz}} : a_out;
    assign b = bus.oeb_ ? {WIDTH{1'bz}} : b_out;
endmodule

// File: tb/tb_am2951_fifo_port.sv
// Directed bench for am2951_fifo_port: inverting instance u0 and true-polarity instance u1.
module tb_am2951_fifo_port;
    logic clk;
    logic rst_;
    int   checks;
    int   errors;

    wire  [7:0] a0, b0, a1, b1;
    logic [7:0] a0_drv, b0_drv, a1_drv, b1_drv;
    logic       a0_en, b0_en, a1_en, b1_en;

    assign a0 = a0_en ? a0_drv : 8'hzz;
    assign b0 = b0_en ? b0_drv : 8'hzz;
    assign a1 = a1_en ? a1_drv : 8'hzz;
    assign b1 = b1_en ? b1_drv : 8'hzz;

    am2951_fifo_port_if #(.DEPTH(4)) if0 ();
    am2951_fifo_port_if #(.DEPTH(4)) if1 ();

    am2951_fifo_port #(.WIDTH(8), .DEPTH(4), .INVERT(1'b1)) u0 (
        .clk (clk), .rst_ (rst_), .a (a0), .b (b0), .bus (if0)
    );
    am2951_fifo_port #(.WIDTH(8), .DEPTH(4), .INVERT(1'b0)) u1 (
        .clk (clk), .rst_ (rst_), .a (a1), .b (b1), .bus (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (if0.fr !== 1'b0)    begin errors++; $display("FAIL reset_fr: got %b exp 0", if0.fr); end
        checks++; if (if0.fs !== 1'b0)    begin errors++; $display("FAIL reset_fs: got %b exp 0", if0.fs); end
        checks++; if (if0.cntr !== 3'd0)  begin errors++; $display("FAIL reset_cntr: got %0d exp 0", if0.cntr); end
        checks++; if (if0.ovr !== 1'b0)   begin errors++; $display("FAIL reset_ovr: got %b exp 0", if0.ovr); end
        checks++; if (if0.fullr !== 1'b0) begin errors++; $display("FAIL reset_fullr: got %b exp 0", if0.fullr); end
        // With oe*_ high the DUT must not fight the bench drivers.
        checks++; if (a0 !== 8'h5A) begin errors++; $display("FAIL reset_a_hiz: got %h exp 5a", a0); end
        checks++; if (b0 !== 8'hA5) begin errors++; $display("FAIL reset_b_hiz: got %h exp a5", b0); end
        step();
        rst_ = 1'b1;
        step();
    endtask

    task automatic test_fill_drain();
        if0.cer_ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a0_drv = 8'(17 * (i + 1));
            step();
        end
        if0.cer_ = 1'b1;
        checks++; if (if0.cntr !== 3'd4)  begin errors++; $display("FAIL fill_cntr: got %0d exp 4", if0.cntr); end
        checks++; if (if0.fullr !== 1'b1) begin errors++; $display("FAIL fill_fullr: got %b exp 1", if0.fullr); end
        b0_en = 1'b0;
        if0.oeb_ = 1'b0;
        #1;
        checks++; if (b0 !== 8'hEE) begin errors++; $display("FAIL fill_head: got %h exp ee", b0); end
        if0.rdr_ = 1'b0;
        step();
        checks++; if (b0 !== 8'hDD) begin errors++; $display("FAIL drain_1: got %h exp dd", b0); end
        step();
        checks++; if (b0 !== 8'hCC) begin errors++; $display("FAIL drain_2: got %h exp cc", b0); end
        step();
        checks++; if (b0 !== 8'hBB) begin errors++; $display("FAIL drain_3: got %h exp bb", b0); end
        checks++; if (if0.fullr !== 1'b0) begin errors++; $display("FAIL drain_fullr: got %b exp 0", if0.fullr); end
        step();
        if0.rdr_ = 1'b1;
        checks++; if (if0.fr !== 1'b0)   begin errors++; $display("FAIL drain_fr: got %b exp 0", if0.fr); end
        checks++; if (if0.cntr !== 3'd0) begin errors++; $display("FAIL drain_cntr: got %0d exp 0", if0.cntr); end
    endtask

    task automatic test_overflow();
        if0.cer_ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a0_drv = 8'(17 * (i + 1));
            step();
        end
        a0_drv = 8'h55;
        step();
        if0.cer_ = 1'b1;
        checks++; if (if0.ovr !== 1'b1)   begin errors++; $display("FAIL ovf_set: got %b exp 1", if0.ovr); end
        checks++; if (if0.cntr !== 3'd4)  begin errors++; $display("FAIL ovf_cntr: got %0d exp 4", if0.cntr); end
        checks++; if (b0 !== 8'hEE)       begin errors++; $display("FAIL ovf_head: got %h exp ee", b0); end
        if0.cer_ = 1'b0;
        if0.rdr_ = 1'b0;
        step();
        if0.cer_ = 1'b1;
        checks++; if (if0.cntr !== 3'd4)  begin errors++; $display("FAIL fullpp_cntr: got %0d exp 4", if0.cntr); end
        checks++; if (if0.fullr !== 1'b1) begin errors++; $display("FAIL fullpp_fullr: got %b exp 1", if0.fullr); end
        checks++; if (b0 !== 8'hDD)       begin errors++; $display("FAIL fullpp_head: got %h exp dd", b0); end
        step();
        checks++; if (b0 !== 8'hCC) begin errors++; $display("FAIL fullpp_d1: got %h exp cc", b0); end
        step();
        checks++; if (b0 !== 8'hBB) begin errors++; $display("FAIL fullpp_d2: got %h exp bb", b0); end
        step();
        checks++; if (b0 !== 8'hAA) begin errors++; $display("FAIL fullpp_0x55: got %h exp aa", b0); end
        step();
        if0.rdr_ = 1'b1;
        checks++; if (if0.cntr !== 3'd0) begin errors++; $display("FAIL fullpp_empty: got %0d exp 0", if0.cntr); end
        checks++; if (if0.ovr !== 1'b1)  begin errors++; $display("FAIL ovf_sticky: got %b exp 1", if0.ovr); end
        if0.clrr = 1'b1;
        step();
        if0.clrr = 1'b0;
        checks++; if (if0.ovr !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b exp 0", if0.ovr); end
    endtask

    task automatic test_empty_push_pop();
        logic [7:0] v;
        logic [7:0] e;
        if0.cer_ = 1'b0;
        if0.rdr_ = 1'b0;
        a0_drv = 8'hA5;
        step();
        if0.cer_ = 1'b1;
        if0.rdr_ = 1'b1;
        checks++; if (if0.cntr !== 3'd1) begin errors++; $display("FAIL emptypp_cntr: got %0d exp 1", if0.cntr); end
        checks++; if (b0 !== 8'h5A)      begin errors++; $display("FAIL emptypp_head: got %h exp 5a", b0); end
        // One word in flight; each push+pop replaces it, walking both pointers round the ring.
        for (int i = 0; i < 10; i++) begin
            v = 8'(8'h30 + 7 * i);
            e = ~v;
            a0_drv = v;
            if0.cer_ = 1'b0;
            if0.rdr_ = 1'b0;
            step();
            checks++; if (b0 !== e) begin errors++; $display("FAIL wrap_%0d: got %h exp %h", i, b0, e); end
            checks++; if (if0.cntr !== 3'd1) begin errors++; $display("FAIL wrap_cnt_%0d: got %0d exp 1", i, if0.cntr); end
        end
        if0.cer_ = 1'b1;
        step();
        if0.rdr_ = 1'b1;
        checks++; if (if0.cntr !== 3'd0) begin errors++; $display("FAIL wrap_drain: got %0d exp 0", if0.cntr); end
    endtask

    task automatic test_clear();
        if0.oeb_ = 1'b1;
        b0_en = 1'b1;
        if0.ces_ = 1'b0;
        b0_drv = 8'h61;
        step();
        b0_drv = 8'h62;
        step();
        if0.ces_ = 1'b1;
        checks++; if (if0.cnts !== 3'd2) begin errors++; $display("FAIL s_fill: got %0d exp 2", if0.cnts); end
        b0_en = 1'b0;
        if0.oeb_ = 1'b0;
        if0.cer_ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a0_drv = 8'(8'h71 + i);
            step();
        end
        if0.cer_ = 1'b1;
        if0.rdr_ = 1'b0;
        step();
        step();
        if0.rdr_ = 1'b1;
        checks++; if (if0.cntr !== 3'd2) begin errors++; $display("FAIL clr_pre_cnt: got %0d exp 2", if0.cntr); end
        checks++; if (if0.ovr !== 1'b1)  begin errors++; $display("FAIL clr_pre_ovr: got %b exp 1", if0.ovr); end
        if0.clrr = 1'b1;
        if0.cer_ = 1'b0;
        if0.rdr_ = 1'b0;
        a0_drv = 8'h76;
        step();
        if0.clrr = 1'b0;
        if0.cer_ = 1'b1;
        if0.rdr_ = 1'b1;
        checks++; if (if0.cntr !== 3'd0) begin errors++; $display("FAIL clr_cntr: got %0d exp 0", if0.cntr); end
        checks++; if (if0.fr !== 1'b0)   begin errors++; $display("FAIL clr_fr: got %b exp 0", if0.fr); end
        checks++; if (if0.ovr !== 1'b0)  begin errors++; $display("FAIL clr_ovr: got %b exp 0", if0.ovr); end
        checks++; if (if0.cnts !== 3'd2) begin errors++; $display("FAIL clr_s_cnts: got %0d exp 2", if0.cnts); end
        checks++; if (if0.fs !== 1'b1)   begin errors++; $display("FAIL clr_s_fs: got %b exp 1", if0.fs); end
        if0.cer_ = 1'b0;
        a0_drv = 8'h77;
        step();
        if0.cer_ = 1'b1;
        checks++; if (b0 !== 8'h88) begin errors++; $display("FAIL clr_ptr_head: got %h exp 88", b0); end
        a0_en = 1'b0;
        if0.oea_ = 1'b0;
        #1;
        checks++; if (a0 !== 8'h9E) begin errors++; $display("FAIL s_head: got %h exp 9e", a0); end
        if0.rds_ = 1'b0;
        step();
        if0.rds_ = 1'b1;
        checks++; if (a0 !== 8'h9D)      begin errors++; $display("FAIL s_pop_head: got %h exp 9d", a0); end
        checks++; if (if0.cnts !== 3'd1) begin errors++; $display("FAIL s_pop_cnt: got %0d exp 1", if0.cnts); end
    endtask

    task automatic test_async_reset();
        #3;
        rst_ = 1'b0;
        #1;
        checks++; if (if0.fr !== 1'b0)   begin errors++; $display("FAIL arst_fr: got %b exp 0", if0.fr); end
        checks++; if (if0.fs !== 1'b0)   begin errors++; $display("FAIL arst_fs: got %b exp 0", if0.fs); end
        checks++; if (if0.cntr !== 3'd0) begin errors++; $display("FAIL arst_cntr: got %0d exp 0", if0.cntr); end
        checks++; if (if0.cnts !== 3'd0) begin errors++; $display("FAIL arst_cnts: got %0d exp 0", if0.cnts); end
        if0.oea_ = 1'b1;
        if0.oeb_ = 1'b1;
        a0_en = 1'b1;
        b0_en = 1'b1;
        step();
        rst_ = 1'b1;
        step();
    endtask

    task automatic test_noninvert();
        if1.cer_ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a1_drv = 8'(17 * (i + 1));
            step();
        end
        if1.cer_ = 1'b1;
        b1_en = 1'b0;
        if1.oeb_ = 1'b0;
        #1;
        checks++; if (b1 !== 8'h11)      begin errors++; $display("FAIL noinv_head: got %h exp 11", b1); end
        checks++; if (if1.cntr !== 3'd4) begin errors++; $display("FAIL noinv_cntr: got %0d exp 4", if1.cntr); end
        if1.rdr_ = 1'b0;
        step();
        if1.rdr_ = 1'b1;
        checks++; if (b1 !== 8'h22) begin errors++; $display("FAIL noinv_pop: got %h exp 22", b1); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_   = 1'b0;
        a0_en = 1'b1; a0_drv = 8'h5A; b0_en = 1'b1; b0_drv = 8'hA5;
        a1_en = 1'b1; a1_drv = 8'h00; b1_en = 1'b1; b1_drv = 8'h00;
        if0.oea_ = 1'b1; if0.cer_ = 1'b1; if0.rds_ = 1'b1; if0.clrr = 1'b0;
        if0.oeb_ = 1'b1; if0.ces_ = 1'b1; if0.rdr_ = 1'b1; if0.clrs = 1'b0;
        if1.oea_ = 1'b1; if1.cer_ = 1'b1; if1.rds_ = 1'b1; if1.clrr = 1'b0;
        if1.oeb_ = 1'b1; if1.ces_ = 1'b1; if1.rdr_ = 1'b1; if1.clrs = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_empty_push_pop();
        test_clear();
        test_async_reset();
        test_noninvert();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
